// File: rtl/uart_rx_framed.sv
// Framed UART receiver: 5-9 data bits, optional parity, 1-2 stop bits, with a
// one-word holding register (valid/ready) that flags parity/framing errors and overruns.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_RX_Serial,
  input  logic                 i_RX_Ready,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_RX_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS > STOP_BITS ? DATA_BITS : STOP_BITS);
  localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_sync;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 done, done_nxt;
  logic                 full;
  logic                 accept;

  assign full      = (cnt == FULL);
  assign o_RX_Busy = (state != S_IDLE);
  assign accept    = o_RX_DV & i_RX_Ready;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      perr    <= perr_nxt;
      ferr    <= ferr_nxt;
      done    <= done_nxt;
    end
  end

  // idx counts data bits, then is reused to count stop bits.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_sync) begin
          state_nxt = S_START;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (cnt == HALF) begin
          cnt_nxt   = '0;
          state_nxt = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (full) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_sync;
          if (idx == LAST_DATA) begin
            idx_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (full) begin
          cnt_nxt   = '0;
          perr_nxt  = (^shift) ^ rx_sync ^ ODD;
          state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (full) begin
          cnt_nxt = '0;
          if (!rx_sync) ferr_nxt = 1'b1;
          if (idx == LAST_STOP) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            // A low final stop bit may be a break; wait for the line to recover.
            state_nxt = rx_sync ? S_IDLE : S_WAIT_IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Holding register: a completed frame loads only if the slot is free or
  // being emptied this cycle; otherwise it is dropped and flagged.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
    end else if (done && (!o_RX_DV || accept)) begin
      o_RX_DV      <= 1'b1;
      o_RX_Byte    <= shift;
      o_Parity_Err <= perr;
      o_Frame_Err  <= ferr;
      o_Overrun    <= 1'b0;
    end else if (accept) begin
      o_RX_DV      <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
    end else if (done) begin
      o_Overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three instances (8N1, 8E1, 7O2) at 16 clocks/bit,
// directed frames against a frame-level expectation queue plus literal checks.
module tb_uart_rx_framed;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0, rx1, rx2, rdy0, rdy1, rdy2;
  logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, busy0, busy1, busy2;
  logic [7:0] byte0, byte1;
  logic [6:0] byte2;

  always #5 clk = ~clk;

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx0), .i_RX_Ready(rdy0),
    .o_RX_DV(dv0), .o_RX_Byte(byte0), .o_Parity_Err(pe0), .o_Frame_Err(fe0),
    .o_Overrun(ov0), .o_RX_Busy(busy0));
  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) d1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx1), .i_RX_Ready(rdy1),
    .o_RX_DV(dv1), .o_RX_Byte(byte1), .o_Parity_Err(pe1), .o_Frame_Err(fe1),
    .o_Overrun(ov1), .o_RX_Busy(busy1));
  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) d2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx2), .i_RX_Ready(rdy2),
    .o_RX_DV(dv2), .o_RX_Byte(byte2), .o_Parity_Err(pe2), .o_Frame_Err(fe2),
    .o_Overrun(ov2), .o_RX_Busy(busy2));

  typedef struct packed { logic [8:0] data; logic pe; logic fe; } exp_t;
  typedef struct packed { logic dv; logic [8:0] b; logic pe; logic fe; logic ov; logic busy; } obs_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Frame-level model: what a receiver must report for the bits put on the wire.
  function automatic exp_t model(input logic [8:0] d, input int nbits, input int pmode,
                                 input logic pbit, input logic stopv);
    exp_t e;
    int ones;
    e.data = d & 9'((1 << nbits) - 1);
    ones = $countones(e.data) + int'(pbit);
    e.pe = (pmode != 0) && ((ones % 2) != ((pmode == 2) ? 1 : 0));
    e.fe = !stopv;
    return e;
  endfunction

  function automatic obs_t get(input int i);
    obs_t o;
    case (i)
      0:       o = '{dv0, {1'b0, byte0}, pe0, fe0, ov0, busy0};
      1:       o = '{dv1, {1'b0, byte1}, pe1, fe1, ov1, busy1};
      default: o = '{dv2, {2'b0, byte2}, pe2, fe2, ov2, busy2};
    endcase
    return o;
  endfunction

  function automatic logic rdy(input int i);
    return (i == 0) ? rdy0 : (i == 1) ? rdy1 : rdy2;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int i, output exp_t e);
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Every accepted word must be the next expected frame; idle flags must be clear.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        obs_t o;
        exp_t e;
        o = get(i);
        if (!o.dv) begin
          chk($sformatf("d%0d_idle_flags", i), 32'({o.pe, o.fe, o.ov}), 32'd0);
        end else if (rdy(i)) begin
          if (qsize(i) == 0) begin
            chk($sformatf("d%0d_unexpected_dv", i), 32'(o.b), 32'h1ff);
          end else begin
            qpop(i, e);
            chk($sformatf("d%0d_byte", i), 32'(o.b), 32'(e.data));
            chk($sformatf("d%0d_perr", i), 32'(o.pe), 32'(e.pe));
            chk($sformatf("d%0d_ferr", i), 32'(o.fe), 32'(e.fe));
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_line(input int i, input logic v);
    case (i)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send(input int i, input logic [8:0] d, input int nbits, input int pmode,
                      input logic pbit, input int nstop, input logic stopv, input bit push);
    if (push) qpush(i, model(d, nbits, pmode, pbit, stopv));
    set_line(i, 1'b0); clks(CPB);
    for (int b = 0; b < nbits; b++) begin set_line(i, d[b]); clks(CPB); end
    if (pmode != 0) begin set_line(i, pbit); clks(CPB); end
    for (int s = 0; s < nstop; s++) begin set_line(i, stopv); clks(CPB); end
    if (stopv) set_line(i, 1'b1);
  endtask

  task automatic wait_chk(input string nm, input int i, input logic [8:0] eb,
                          input logic epe, input logic efe, output int lat);
    obs_t o;
    lat = 0;
    do begin @(negedge clk); lat++; o = get(i); end while (!o.dv && lat < 400);
    if (!o.dv) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_byte"}, 32'(o.b), 32'(eb));
      chk({nm, "_perr"}, 32'(o.pe), 32'(epe));
      chk({nm, "_ferr"}, 32'(o.fe), 32'(efe));
      chk({nm, "_ovr"}, 32'(o.ov), 32'd0);
      @(negedge clk);
      o = get(i);
      chk({nm, "_pulse"}, 32'(o.dv), 32'd0);
    end
  endtask

  task automatic send_chk(input string nm, input int i, input logic [8:0] d, input int nbits,
                          input int pmode, input logic pbit, input int nstop, input logic stopv,
                          input logic [8:0] eb, input logic epe, input logic efe, output int lat);
    int l;
    fork
      send(i, d, nbits, pmode, pbit, nstop, stopv, 1'b1);
      wait_chk(nm, i, eb, epe, efe, l);
    join
    lat = l;
  endtask

  initial begin
    int lat, n;
    obs_t o;
    rst_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d_reset", i), 32'(get(i)), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clks(4);

    // 8N1 0x6B; DV due at 2 sync + 9 setup + 9*16 bits + 1 load = 156 clocks
    send_chk("t1", 0, 9'h6B, 8, 0, 1'b0, 1, 1'b1, 9'h6B, 1'b0, 1'b0, lat);
    chk("t1_latency_ok", 32'(lat >= 150 && lat <= 160), 32'd1);
    clks(2 * CPB);

    // even parity: correct parity bit for 0x6B (five ones) is 1
    send_chk("t2_bad", 1, 9'h6B, 8, 1, 1'b0, 1, 1'b1, 9'h6B, 1'b1, 1'b0, lat);
    clks(2 * CPB);
    send_chk("t2_good", 1, 9'h6B, 8, 1, 1'b1, 1, 1'b1, 9'h6B, 1'b0, 1'b0, lat);
    clks(2 * CPB);

    // break: low stop bit then line held low
    send_chk("t3", 0, 9'h00, 8, 0, 1'b0, 1, 1'b0, 9'h00, 1'b0, 1'b1, lat);
    n = 0;
    for (int k = 0; k < 40 * CPB; k++) begin
      clks(1);
      if (!busy0) n++;
    end
    chk("t3_busy_low_cycles", 32'(n), 32'd0);
    set_line(0, 1'b1);
    clks(5);
    chk("t3_busy_released", 32'(busy0), 32'd0);
    clks(2 * CPB);

    // 4-clock glitch on an idle line
    n = 0;
    set_line(0, 1'b0);
    fork
      begin clks(4); set_line(0, 1'b1); end
      for (int k = 0; k < 48; k++) begin @(negedge clk); if (busy0) n++; end
    join
    chk("t4_busy_seen", 32'(n > 0), 32'd1);
    chk("t4_busy_bounded", 32'(n <= 9), 32'd1);
    clks(2 * CPB);

    // overrun: consumer stalled across two frames
    rdy0 = 1'b0;
    send(0, 9'h11, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    clks(CPB);
    send(0, 9'h22, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    clks(CPB);
    o = get(0);
    chk("t5_held_dv", 32'(o.dv), 32'd1);
    chk("t5_held_byte", 32'(o.b), 32'h11);
    chk("t5_overrun", 32'(o.ov), 32'd1);
    rdy0 = 1'b1;
    clks(1);
    rdy0 = 1'b0;
    @(negedge clk);
    chk("t5_dv_cleared", 32'(dv0), 32'd0);
    chk("t5_ovr_cleared", 32'(ov0), 32'd0);
    clks(3 * CPB);
    chk("t5_no_second", 32'(dv0), 32'd0);
    rdy0 = 1'b1;

    // 7O2: 0x55 has four ones, odd parity bit 1
    rdy2 = 1'b0;
    send(2, 9'h55, 7, 2, 1'b1, 2, 1'b1, 1'b0);
    clks(CPB);
    o = get(2);
    chk("t6_held", 32'({o.dv, o.b, o.pe, o.fe, o.ov}), 32'({1'b1, 9'h55, 3'b000}));
    set_line(2, 1'b0); clks(CPB);
    set_line(2, 1'b1); clks(3 * CPB / 2);
    chk("t6_busy_mid", 32'(busy2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 32'(get(2)), 32'd0);
    q2.delete();
    clks(3);
    rst_n = 1'b1;
    clks(3);
    rdy2 = 1'b1;
    // 0x2A has three ones, odd parity bit 0
    send_chk("t6_2a", 2, 9'h2A, 7, 2, 1'b0, 2, 1'b1, 9'h2A, 1'b0, 1'b0, lat);
    clks(2 * CPB);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
